uart_rx_oversampled: RTL and testbench
======================================

// Module: uart_rx_oversampled
// PURPOSE
//  UART receiver that feeds the command interface: deserializes 8N1 frames from the rx pin into d_out bytes.
//  Each good byte is flagged by a 1-cycle rx_done pulse.
//  Contains its own 16x oversample tick generator, a 2-FF input synchronizer and framing-error detection.
//  Sits between the board rx pin and the interface FSM's d_in/rx_done inputs.
// PARAMETERS
//  DBIT    8    data bits per frame, LSB first
//  SB_TICK 16   oversample ticks spent in stop bit (16 = 1 stop bit)
//  CLK_DIV 163  clk cycles per oversample tick (50 MHz / (19200*16))
// PORTS
//  clk        in   1     system clock, all logic on posedge
//  reset      in   1     asynchronous, active-high; clears all state
//  rx         in   1     serial line, idle high, asynchronous to clk
//  d_out      out  DBIT  last correctly framed byte
//  rx_done    out  1     1-cycle pulse; d_out valid in same cycle
//  frame_err  out  1     1-cycle pulse when stop bit samples low
//  busy       out  1     high in any state other than IDLE
// BEHAVIOUR
//  Reset (async, active-high): d_out=0, rx_done=0, frame_err=0, busy=0; state=IDLE; tick_cnt=0, s_cnt=0, n_cnt=0; sync FFs=1.
//  Sync: rx passes two FFs -> rx_s; FSM uses only rx_s, so 2-cycle input latency.
//  Tick gen:
//   - tick_cnt runs 0..CLK_DIV-1 freely; tick=1 for one clk when tick_cnt==CLK_DIV-1, then wraps to 0.
//   - Never reset by the FSM.
//  FSM states IDLE, START, DATA, STOP, WAIT_IDLE:
//   IDLE: when rx_s==0 -> START, s_cnt=0. Checked every clk, not only on tick.
//   START: on tick s_cnt++.
//    - When tick and s_cnt==7 (mid start bit): if rx_s==0 -> DATA, s_cnt=0, n_cnt=0.
//    - Otherwise glitch -> IDLE, no pulses.
//   DATA: on tick s_cnt++.
//    - When tick and s_cnt==15: shift register b = {rx_s, b[DBIT-1:1]}, s_cnt=0.
//    - If n_cnt==DBIT-1 -> STOP, else n_cnt++.
//   STOP: on tick s_cnt++.
//    - When tick and s_cnt==SB_TICK-1: if rx_s==1: d_out<=b, rx_done=1 for that cycle, -> IDLE.
//    - If rx_s==0: frame_err=1 for that cycle, d_out unchanged, -> WAIT_IDLE.
//   WAIT_IDLE: stay until rx_s==1, then -> IDLE (break/held-low line yields one frame_err only).
//  rx_done and frame_err are registered, never both high, and each is high exactly one clk.
//  A new start bit directly after a stop bit is accepted; back-to-back frames need no extra idle time.
//  Reset mid-frame aborts the frame with no pulses.
//   - A following low rx is treated as a fresh start edge.
//  Counters: s_cnt 4 bits (SB_TICK<=16 required), n_cnt clog2(DBIT) bits; no other arithmetic.
//  Baud error tolerance: sampling at tick 7 then every 16 ticks gives centre sampling.
//   - Designed for +/-3% total clock mismatch.
// TESTING (CLK_DIV=4 in bench for speed; bit time = 64 clk)
//  1 Reset: assert reset 3 clk with rx=1 -> d_out=0, rx_done=0, frame_err=0, busy=0; tick every 4th clk after release.
//  2 Byte 0xA5 (start,1,0,1,0,0,1,0,1,stop) -> exactly one rx_done pulse, d_out=8'hA5, frame_err stays 0, busy falls with rx_done.
//  3 Back-to-back 0x01,0x02,0x03,0x04 (interface code/addr stream) with no idle gap -> four rx_done pulses, d_out 01,02,03,04 in order.
//  4 Glitch: rx low for 12 clk (<half bit) -> returns to IDLE, no rx_done, no frame_err; following 0x3C still received correctly.
//  5 Frame error: send 0x55 with stop bit 0, then hold rx low 200 clk -> one frame_err pulse, no rx_done, d_out keeps prior value, busy stays high until rx returns high.
//  6 Reset mid-frame: assert reset during bit 4 of 0xFF -> outputs cleared asynchronously, no pulse; next 0x7E received as 8'h7E.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver with a free-running 16x oversample tick, a 2-FF rx synchronizer
// and framing-error detection; good bytes appear on d_out with a 1-cycle rx_done.
module uart_rx_oversampled #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int CLK_DIV = 163
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    output logic [DBIT-1:0] d_out,
    output logic            rx_done,
    output logic            frame_err,
    output logic            busy
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_rx_meta;
    logic            r_rx_s;
    logic [TW-1:0]   r_tick_cnt;
    logic            w_tick;
    logic [3:0]      r_s_cnt;
    logic [NW-1:0]   r_n_cnt;
    logic [DBIT-1:0] r_shift;
    logic [DBIT-1:0] r_d_out;
    logic            r_rx_done;
    logic            r_frame_err;
    logic            w_mid_start;
    logic            w_mid_data;
    logic            w_end_stop;
    logic            w_n_last;
    logic            w_done_set;
    logic            w_err_set;

    // Sync FFs reset high so an idle line is not mistaken for a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_tick      = (r_tick_cnt == TW'(CLK_DIV - 1));
    assign w_mid_start = w_tick && (r_s_cnt == 4'd7);
    assign w_mid_data  = w_tick && (r_s_cnt == 4'd15);
    assign w_end_stop  = w_tick && (r_s_cnt == 4'(SB_TICK - 1));
    assign w_n_last    = (r_n_cnt == NW'(DBIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (!r_rx_s) w_next_state = START;
            START:     if (w_mid_start) w_next_state = r_rx_s ? IDLE : DATA;
            DATA:      if (w_mid_data && w_n_last) w_next_state = STOP;
            STOP:      if (w_end_stop) w_next_state = r_rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (r_rx_s) w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_done_set = 1'b0;
        w_err_set  = 1'b0;
        busy       = (r_state != IDLE);
        if (r_state == STOP && w_end_stop) begin
            w_done_set = r_rx_s;
            w_err_set  = !r_rx_s;
        end
    end

    // Counters and shifter; s_cnt restarts at each sampling point so bits stay centred.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s_cnt     <= '0;
            r_n_cnt     <= '0;
            r_shift     <= '0;
            r_d_out     <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_done   <= w_done_set;
            r_frame_err <= w_err_set;
            if (w_done_set) begin
                r_d_out <= r_shift;
            end
            case (r_state)
                START: begin
                    if (w_mid_start) begin
                        r_s_cnt <= '0;
                        r_n_cnt <= '0;
                    end else if (w_tick) begin
                        r_s_cnt <= r_s_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_mid_data) begin
                        r_s_cnt <= '0;
                        r_shift <= {r_rx_s, r_shift[DBIT-1:1]};
                        if (!w_n_last) begin
                            r_n_cnt <= r_n_cnt + 1'b1;
                        end
                    end else if (w_tick) begin
                        r_s_cnt <= r_s_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_end_stop) begin
                        r_s_cnt <= '0;
                    end else if (w_tick) begin
                        r_s_cnt <= r_s_cnt + 1'b1;
                    end
                end
                default: r_s_cnt <= '0;
            endcase
        end
    end

    assign d_out     = r_d_out;
    assign rx_done   = r_rx_done;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: frames are driven at 64 clk per bit and
// each expected rx_done/frame_err event is queued for an independent monitor.
module tb_uart_rx_oversampled;

    localparam int BIT_CLKS = 64;

    typedef struct packed {
        logic       isErr;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] d_out;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    exp_t       expQ[$];
    exp_t       monEntry;
    logic [7:0] lastGood;
    int         checks;
    int         errors;

    uart_rx_oversampled #(
        .DBIT    (8),
        .SB_TICK (16),
        .CLK_DIV (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .d_out     (d_out),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic idle(input int clks);
        rx = 1'b1;
        repeat (clks) @(negedge clk);
    endtask

    // Model: a good stop bit yields that byte; a low stop bit yields an error with d_out held.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        logic [9:0] frame;
        frame = {stopBit, data, 1'b0};
        if (stopBit) begin
            expQ.push_back('{isErr: 1'b0, data: data});
            lastGood = data;
        end else begin
            expQ.push_back('{isErr: 1'b1, data: lastGood});
        end
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
    endtask

    task automatic glitch(input int clks);
        rx = 1'b0;
        repeat (clks) @(negedge clk);
        idle(BIT_CLKS);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 400 && expQ.size() != 0; i++) @(negedge clk);
        checkOutput("drain", 32'(expQ.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!reset && (rx_done || frame_err)) begin
            checkOutput("exclusive", 32'(rx_done & frame_err), 32'd0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_pulse", {30'd0, frame_err, rx_done}, 32'd0);
            end else begin
                monEntry = expQ.pop_front();
                checkOutput("pulse_kind", 32'(frame_err), 32'(monEntry.isErr));
                checkOutput("d_out", 32'(d_out), 32'(monEntry.data));
                checkOutput("busy_at_pulse", 32'(busy), 32'(monEntry.isErr));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic       found;
        logic [7:0] rdata;
        logic       rstop;
        checks   = 0;
        errors   = 0;
        lastGood = 8'h00;
        found    = 1'b0;

        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_d_out", 32'(d_out), 32'd0);
        checkOutput("reset_rx_done", 32'(rx_done), 32'd0);
        checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (dut.w_tick) found = 1'b1;
        end
        checkOutput("tick_seen", 32'(found), 32'd1);
        if (found) begin
            for (int p = 0; p < 2; p++) begin
                for (int k = 1; k <= 4; k++) begin
                    @(negedge clk);
                    checkOutput("tick_period", 32'(dut.w_tick), 32'(k == 4));
                end
            end
        end

        $display("[TB] single byte 0xA5");
        idle(BIT_CLKS);
        applyStimulus(8'hA5, 1'b1);
        idle(BIT_CLKS);
        waitDrain();

        $display("[TB] back-to-back 01..04");
        for (int b = 1; b <= 4; b++) applyStimulus(8'(b), 1'b1);
        idle(BIT_CLKS);
        waitDrain();

        $display("[TB] glitch then 0x3C");
        glitch(12);
        applyStimulus(8'h3C, 1'b1);
        idle(BIT_CLKS);
        waitDrain();

        $display("[TB] framing error on 0x55");
        applyStimulus(8'h55, 1'b0);
        rx = 1'b0;
        repeat (200) @(negedge clk);
        waitDrain();
        checkOutput("busy_held_low", 32'(busy), 32'd1);
        idle(8);
        checkOutput("busy_after_release", 32'(busy), 32'd0);
        idle(BIT_CLKS);

        $display("[TB] reset during 0xFF");
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        checkOutput("busy_mid_frame", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("async_d_out", 32'(d_out), 32'd0);
        checkOutput("async_busy", 32'(busy), 32'd0);
        checkOutput("async_pulses", {30'd0, frame_err, rx_done}, 32'd0);
        lastGood = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(BIT_CLKS);
        applyStimulus(8'h7E, 1'b1);
        idle(BIT_CLKS);
        waitDrain();

        $display("[TB] randomized frames");
        for (int n = 0; n < 24; n++) begin
            rdata = 8'($urandom);
            rstop = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 4) == 0) glitch($urandom_range(1, 20));
            applyStimulus(rdata, rstop);
            if (!rstop) begin
                rx = 1'b0;
                repeat ($urandom_range(0, 150)) @(negedge clk);
                idle(BIT_CLKS + $urandom_range(0, 20));
            end else if ($urandom_range(0, 2) != 0) begin
                idle($urandom_range(1, 100));
            end
        end
        idle(BIT_CLKS);
        waitDrain();
        checkOutput("final_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
